acc_f32: RTL

ACC_F32 -- requirements
Module: acc_f32

---
 rtl/acc_f32_pkg.sv | 25 ++
 rtl/acc_f32_add.sv | 122 ++++++++++++
 rtl/acc_f32.sv | 102 ++++++++++
 3 files changed

// File: rtl/acc_f32_pkg.sv
// Shared constants, state encoding and the float payload layout for the
// single-precision accumulator.
package acc_f32_pkg;

    localparam int unsigned F32_WIDTH  = 32;
    localparam int unsigned F32_EXP_W  = 8;
    localparam int unsigned F32_MANT_W = 23;
    localparam int unsigned CNT_W      = 8;

    localparam logic [F32_WIDTH-1:0] F32_ZERO = 32'h0000_0000;
    localparam logic [F32_WIDTH-1:0] F32_NAN  = 32'h7fff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  sign;
        logic [F32_EXP_W-1:0]  exp;
        logic [F32_MANT_W-1:0] mant;
    } f32_t;

endpackage

// File: rtl/acc_f32_add.sv
// Combinational IEEE-754 adder: round-to-nearest-even, subnormals kept,
// any NaN collapses to the canonical 0x7fffffff, inf - inf is NaN.
module acc_f32_add #(
    parameter int unsigned EXPONENTWIDTH = 8,
    parameter int unsigned MANTISSAWIDTH = 23,
    parameter int unsigned WIDTH         = 1 + EXPONENTWIDTH + MANTISSAWIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c
);

    localparam int unsigned EW = EXPONENTWIDTH;
    localparam int unsigned MW = MANTISSAWIDTH;
    localparam int unsigned FW = MW + 1;    // significand with hidden bit
    localparam int unsigned XW = FW + 3;    // plus guard/round/sticky
    localparam int unsigned SW = XW + 1;    // plus carry
    localparam int unsigned RW = EW + 2;    // exponent with headroom

    localparam logic [EW-1:0]    E_ALL = '1;
    localparam logic [WIDTH-1:0] NAN_V = {1'b0, {(WIDTH-1){1'b1}}};

    logic          sa, sb;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          nan_a, nan_b, inf_a, inf_b;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign nan_a = (ea == E_ALL) && (fa != '0);
    assign nan_b = (eb == E_ALL) && (fb != '0);
    assign inf_a = (ea == E_ALL) && (fa == '0);
    assign inf_b = (eb == E_ALL) && (fb == '0);

    logic          swap, sx, sy, found, rnd_up;
    logic [EW-1:0] ex, ey, exf, eyf, d, res_e;
    logic [MW-1:0] fx, fy;
    logic [XW-1:0] mx, my, my_sh, mask, n;
    logic [SW-1:0] s;
    logic [RW-1:0] er, lz, sh;
    logic [FW:0]   m;

    // Align the smaller magnitude, add or subtract, normalise, round.
    always_comb begin
        swap   = b[WIDTH-2:0] > a[WIDTH-2:0];
        sx     = swap ? sb : sa;
        sy     = swap ? sa : sb;
        ex     = swap ? eb : ea;
        ey     = swap ? ea : eb;
        fx     = swap ? fb : fa;
        fy     = swap ? fa : fb;
        exf    = (ex == '0) ? EW'(1) : ex;
        eyf    = (ey == '0) ? EW'(1) : ey;
        d      = exf - eyf;
        mx     = {(ex != '0), fx, 3'b000};
        my     = {(ey != '0), fy, 3'b000};
        mask   = '0;
        my_sh  = '0;
        s      = '0;
        n      = '0;
        er     = RW'(exf);
        lz     = '0;
        sh     = '0;
        found  = 1'b0;
        rnd_up = 1'b0;
        m      = '0;
        res_e  = '0;
        sum_c  = '0;

        if (32'(d) >= XW) begin
            my_sh = {{(XW-1){1'b0}}, |my};
        end else begin
            mask  = ~({XW{1'b1}} << d);
            my_sh = (my >> d) | {{(XW-1){1'b0}}, |(my & mask)};
        end

        if (sx == sy) s = {1'b0, mx} + {1'b0, my_sh};
        else          s = {1'b0, mx} - {1'b0, my_sh};

        if (s[SW-1]) begin
            n  = {s[SW-1:2], |s[1:0]};
            er = er + RW'(1);
        end else begin
            n = s[XW-1:0];
            for (int i = int'(XW) - 1; i >= 0; i--) begin
                if (!found) begin
                    if (n[i]) found = 1'b1;
                    else      lz    = lz + RW'(1);
                end
            end
            // Never shift below the minimum exponent: leaves a subnormal.
            sh = (lz < er - RW'(1)) ? lz : er - RW'(1);
            n  = n << sh;
            er = er - sh;
        end

        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        m      = {1'b0, n[XW-1:3]} + (FW+1)'(rnd_up);
        if (m[FW]) begin
            m  = m >> 1;
            er = er + RW'(1);
        end
        res_e = m[FW-1] ? er[EW-1:0] : '0;

        if (nan_a || nan_b) begin
            sum_c = NAN_V;
        end else if (inf_a && inf_b && (sa != sb)) begin
            sum_c = NAN_V;
        end else if (inf_a) begin
            sum_c = a;
        end else if (inf_b) begin
            sum_c = b;
        end else if (s == '0) begin
            sum_c = {sx & sy, {(WIDTH-1){1'b0}}};
        end else if (m[FW-1] && (er >= RW'(E_ALL))) begin
            sum_c = {sx, E_ALL, {MW{1'b0}}};
        end else begin
            sum_c = {sx, res_e, m[MW-1:0]};
        end
    end

endmodule

// File: rtl/acc_f32.sv
// Streaming float accumulator: sums len operands into a registered result
// and presents it with a valid/ready handshake.
module acc_f32
    import acc_f32_pkg::*;
#(
    parameter int unsigned WIDTH         = F32_WIDTH,
    parameter int unsigned EXPONENTWIDTH = F32_EXP_W,
    parameter int unsigned MANTISSAWIDTH = F32_MANT_W,
    parameter int unsigned CNTWIDTH      = CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNTWIDTH-1:0] len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_sum,
    output logic                busy
);

    state_t              state;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    add_sum_c;
    logic [CNTWIDTH-1:0] cnt;
    logic [CNTWIDTH-1:0] len_q;
    logic                accept_c;
    logic                last_c;

    assign accept_c = in_valid & in_ready;
    // Compared one bit wider so len = max never wraps the count.
    assign last_c   = ({1'b0, cnt} + (CNTWIDTH+1)'(1)) == {1'b0, len_q};
    assign out_sum  = acc;

    acc_f32_add #(
        .EXPONENTWIDTH (EXPONENTWIDTH),
        .MANTISSAWIDTH (MANTISSAWIDTH),
        .WIDTH         (WIDTH)
    ) u_add_f32 (
        .a     (acc),
        .b     (in_data),
        .sum_c (add_sum_c)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= WIDTH'(F32_ZERO);
            cnt       <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= WIDTH'(F32_ZERO);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ST_ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept_c) begin
                        acc <= add_sum_c;
                        cnt <= cnt + CNTWIDTH'(1);
                        if (last_c) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
